// File: rtl/game_timer.sv
// rtl/game_timer.sv - whole-second countdown timer with pause, saturating bonus, BCD digits and game-over flag
module game_timer #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int START_SECONDS = 30,
   parameter int MAX_SECONDS   = 99,
   parameter int BONUS_SECONDS = 3,
   parameter int WARN_SECONDS  = 5,
   parameter int SEC_WIDTH     = 7,
   parameter int PRE_WIDTH     = 27
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   input  logic                 i_restart_game,
   input  logic                 i_pause,
   input  logic                 i_bonus,
   output logic [SEC_WIDTH-1:0] seconds,
   output logic [3:0]           sec_tens,
   output logic [3:0]           sec_ones,
   output logic                 o_tick,
   output logic                 warning,
   output logic                 game_over
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   localparam logic [PRE_WIDTH-1:0] PRE_LAST  = PRE_WIDTH'(TICKS_PER_SEC - 1);
   localparam logic [SEC_WIDTH-1:0] SEC_START = SEC_WIDTH'(START_SECONDS);
   localparam logic [SEC_WIDTH-1:0] SEC_WARN  = SEC_WIDTH'(WARN_SECONDS);
   localparam logic [SEC_WIDTH:0]   SUM_MAX   = (SEC_WIDTH + 1)'(MAX_SECONDS);
   localparam logic [SEC_WIDTH:0]   SUM_BONUS = (SEC_WIDTH + 1)'(BONUS_SECONDS);

   // Repeated subtract-by-ten; nine passes cover every value up to 99.
   function automatic logic [7:0] to_bcd(input logic [SEC_WIDTH-1:0] value);
      logic [SEC_WIDTH-1:0] v;
      logic [3:0]           t;
      v = value;
      t = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (v >= SEC_WIDTH'(10)) begin
            v = v - SEC_WIDTH'(10);
            t = t + 4'd1;
         end
      end
      return {t, 4'(v)};
   endfunction

   localparam logic [7:0] BCD_START = to_bcd(SEC_START);

   state_t               r_state, w_state_nxt;
   logic [PRE_WIDTH-1:0] r_pre, w_pre_nxt;
   logic [SEC_WIDTH-1:0] r_sec, w_sec_nxt, w_base;
   logic [SEC_WIDTH:0]   w_sum;
   logic [7:0]           w_bcd;
   logic [3:0]           r_tens, r_ones;
   logic                 r_tick, r_warn, r_over;
   logic                 w_tick_now, w_bonus_ok, w_tick_nxt, w_over_nxt, w_warn_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_pre_nxt   = r_pre;
      w_sec_nxt   = r_sec;
      w_tick_nxt  = 1'b0;
      w_over_nxt  = r_over;
      w_tick_now  = (r_state == S_RUN) && (r_pre == PRE_LAST);
      w_bonus_ok  = i_bonus && ((r_state == S_RUN) || (r_state == S_PAUSE));
      w_base      = w_tick_now ? (r_sec - SEC_WIDTH'(1)) : r_sec;
      w_sum       = {1'b0, w_base} + (w_bonus_ok ? SUM_BONUS : '0);
      if (w_sum > SUM_MAX) begin
         w_sum = SUM_MAX;
      end

      if (i_restart_game) begin
         w_state_nxt = S_RUN;
         w_pre_nxt   = '0;
         w_sec_nxt   = SEC_START;
         w_over_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               // A zero start value ends the game one cycle after restart.
               if (r_sec == '0) begin
                  w_state_nxt = S_OVER;
                  w_over_nxt  = 1'b1;
               end else begin
                  w_sec_nxt = w_sum[SEC_WIDTH-1:0];
                  if (w_tick_now) begin
                     w_pre_nxt  = '0;
                     w_tick_nxt = 1'b1;
                     if (w_sum == '0) begin
                        w_state_nxt = S_OVER;
                        w_over_nxt  = 1'b1;
                     end
                  end else if (i_pause) begin
                     w_state_nxt = S_PAUSE;
                  end else begin
                     w_pre_nxt = r_pre + PRE_WIDTH'(1);
                  end
               end
            end
            S_PAUSE: begin
               w_sec_nxt = w_sum[SEC_WIDTH-1:0];
               if (!i_pause) begin
                  w_state_nxt = S_RUN;
               end
            end
            S_OVER: begin
               w_sec_nxt  = '0;
               w_pre_nxt  = '0;
               w_over_nxt = 1'b1;
            end
            default: begin
               w_pre_nxt = '0;
            end
         endcase
      end

      w_warn_nxt = ((w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE)) &&
                   (w_sec_nxt != '0) && (w_sec_nxt <= SEC_WARN);
      w_bcd      = to_bcd(w_sec_nxt);
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_pre   <= '0;
         r_sec   <= SEC_START;
         r_tens  <= BCD_START[7:4];
         r_ones  <= BCD_START[3:0];
         r_tick  <= 1'b0;
         r_warn  <= 1'b0;
         r_over  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pre   <= w_pre_nxt;
         r_sec   <= w_sec_nxt;
         r_tens  <= w_bcd[7:4];
         r_ones  <= w_bcd[3:0];
         r_tick  <= w_tick_nxt;
         r_warn  <= w_warn_nxt;
         r_over  <= w_over_nxt;
      end
   end

   assign seconds   = r_sec;
   assign sec_tens  = r_tens;
   assign sec_ones  = r_ones;
   assign o_tick    = r_tick;
   assign warning   = r_warn;
   assign game_over = r_over;

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - self-checking bench for game_timer with a tick scoreboard
module tb_game_timer;

   localparam int TPS   = 4;
   localparam int START = 3;
   localparam int MAXS  = 5;
   localparam int BON   = 2;
   localparam int WARN  = 2;

   typedef struct {
      int cyc;
      int sec;
      bit over;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, restart, pause, bonus;
   logic [6:0] seconds, seconds2;
   logic [3:0] tens, ones, tens2, ones2;
   logic       tick, warn, over, tick2, warn2, over2;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   game_timer #(
      .TICKS_PER_SEC(TPS), .START_SECONDS(START), .MAX_SECONDS(MAXS),
      .BONUS_SECONDS(BON), .WARN_SECONDS(WARN), .SEC_WIDTH(7), .PRE_WIDTH(27)
   ) dut (
      .clk(clk), .i_rst_n(rst_n), .i_restart_game(restart), .i_pause(pause), .i_bonus(bonus),
      .seconds(seconds), .sec_tens(tens), .sec_ones(ones),
      .o_tick(tick), .warning(warn), .game_over(over)
   );

   game_timer #(
      .TICKS_PER_SEC(TPS), .START_SECONDS(42), .MAX_SECONDS(99),
      .BONUS_SECONDS(BON), .WARN_SECONDS(WARN), .SEC_WIDTH(7), .PRE_WIDTH(27)
   ) dut42 (
      .clk(clk), .i_rst_n(rst_n), .i_restart_game(restart), .i_pause(pause), .i_bonus(bonus),
      .seconds(seconds2), .sec_tens(tens2), .sec_ones(ones2),
      .o_tick(tick2), .warning(warn2), .game_over(over2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
   endtask

   task automatic test_reset();
      int ntick;
      rst_n = 1'b0; restart = 1'b0; pause = 1'b0; bonus = 1'b0;
      step(); step();
      checks++;
      if (seconds !== 7'd3 || tens !== 4'd0 || ones !== 4'd3 || tick !== 1'b0 ||
          warn !== 1'b0 || over !== 1'b0) begin
         errors++;
         $display("FAIL reset_state sec=%0d tens=%0d ones=%0d tick=%b warn=%b over=%b required 3 0 3 0 0 0",
                  seconds, tens, ones, tick, warn, over);
      end
      checks++;
      if (seconds2 !== 7'd42 || tens2 !== 4'd4 || ones2 !== 4'd2) begin
         errors++;
         $display("FAIL reset_bcd42 sec=%0d tens=%0d ones=%0d required 42 4 2", seconds2, tens2, ones2);
      end
      rst_n = 1'b1;
      step();
      bonus = 1'b1; step(); bonus = 1'b0;
      pause = 1'b1; step(); pause = 1'b0;
      ntick = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (tick === 1'b1) ntick++;
      end
      checks++;
      if (seconds !== 7'd3 || ntick != 0 || over !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignore sec=%0d ticks=%0d over=%b required 3 0 0", seconds, ntick, over);
      end
   endtask

   task automatic test_countdown();
      exp_t e;
      int   ntick;
      pulse_restart();
      checks++;
      if (seconds !== 7'd3 || over !== 1'b0 || warn !== 1'b0 || tick !== 1'b0) begin
         errors++;
         $display("FAIL restart_load sec=%0d over=%b warn=%b tick=%b required 3 0 0 0", seconds, over, warn, tick);
      end
      sb_q.push_back('{4, 2, 1'b0});
      sb_q.push_back('{8, 1, 1'b0});
      sb_q.push_back('{12, 0, 1'b1});
      ntick = 0;
      for (int c = 1; c <= 18; c++) begin
         step();
         if (tick === 1'b1) begin
            ntick++;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL countdown_extra_tick cycle=%0d required no tick", c);
            end else begin
               e = sb_q.pop_front();
               if (c != e.cyc || seconds !== 7'(e.sec) || over !== e.over ||
                   tens !== 4'(e.sec / 10) || ones !== 4'(e.sec % 10) ||
                   warn !== ((e.sec != 0) && (e.sec <= WARN))) begin
                  errors++;
                  $display("FAIL countdown_tick cycle=%0d sec=%0d over=%b warn=%b required cycle=%0d sec=%0d over=%b",
                           c, seconds, over, warn, e.cyc, e.sec, e.over);
               end
            end
         end
      end
      checks++;
      if (sb_q.size() != 0 || ntick != 3) begin
         errors++;
         $display("FAIL countdown_count ticks=%0d pending=%0d required 3 0", ntick, sb_q.size());
      end
      sb_q.delete();
      checks++;
      if (seconds !== 7'd0 || over !== 1'b1 || warn !== 1'b0) begin
         errors++;
         $display("FAIL over_state sec=%0d over=%b warn=%b required 0 1 0", seconds, over, warn);
      end
   endtask

   task automatic test_pause();
      exp_t e;
      int   bad;
      pulse_restart();
      step(); step();
      pause = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tick !== 1'b0 || seconds !== 7'd3) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL pause_hold bad_cycles=%0d required 0", bad);
      end
      pause = 1'b0;
      sb_q.push_back('{3, 2, 1'b0});
      for (int c = 1; c <= 6; c++) begin
         step();
         if (tick === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL pause_extra_tick cycle=%0d required no tick", c);
            end else begin
               e = sb_q.pop_front();
               if (c != e.cyc || seconds !== 7'(e.sec)) begin
                  errors++;
                  $display("FAIL pause_resume cycle=%0d sec=%0d required cycle=%0d sec=%0d",
                           c, seconds, e.cyc, e.sec);
               end
            end
         end
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL pause_missing_tick pending=%0d required 0", sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_bonus();
      pulse_restart();
      bonus = 1'b1; step(); bonus = 1'b0;
      checks++;
      if (seconds !== 7'd5 || tens !== 4'd0 || ones !== 4'd5 || warn !== 1'b0) begin
         errors++;
         $display("FAIL bonus_add sec=%0d tens=%0d ones=%0d warn=%b required 5 0 5 0", seconds, tens, ones, warn);
      end
      bonus = 1'b1; step(); bonus = 1'b0;
      checks++;
      if (seconds !== 7'd5 || tens !== 4'd0 || ones !== 4'd5) begin
         errors++;
         $display("FAIL bonus_saturate sec=%0d tens=%0d ones=%0d required 5 0 5", seconds, tens, ones);
      end
      pulse_restart();
      pause = 1'b1; step();
      bonus = 1'b1; step(); bonus = 1'b0;
      checks++;
      if (seconds !== 7'd5 || tick !== 1'b0) begin
         errors++;
         $display("FAIL bonus_in_pause sec=%0d tick=%b required 5 0", seconds, tick);
      end
      restart = 1'b1; bonus = 1'b1; step(); restart = 1'b0; bonus = 1'b0; pause = 1'b0;
      checks++;
      if (seconds !== 7'd3 || over !== 1'b0) begin
         errors++;
         $display("FAIL restart_drops_bonus sec=%0d over=%b required 3 0", seconds, over);
      end
   endtask

   task automatic test_bonus_on_tick();
      exp_t e;
      int   ntick;
      pulse_restart();
      sb_q.push_back('{4, 2, 1'b0});
      sb_q.push_back('{8, 1, 1'b0});
      sb_q.push_back('{12, 2, 1'b0});
      sb_q.push_back('{16, 1, 1'b0});
      sb_q.push_back('{20, 0, 1'b1});
      ntick = 0;
      for (int c = 1; c <= 24; c++) begin
         bonus = (c == 12);
         step();
         if (tick === 1'b1) begin
            ntick++;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL save_extra_tick cycle=%0d required no tick", c);
            end else begin
               e = sb_q.pop_front();
               if (c != e.cyc || seconds !== 7'(e.sec) || over !== e.over ||
                   tens !== 4'(e.sec / 10) || ones !== 4'(e.sec % 10)) begin
                  errors++;
                  $display("FAIL save_tick cycle=%0d sec=%0d over=%b required cycle=%0d sec=%0d over=%b",
                           c, seconds, over, e.cyc, e.sec, e.over);
               end
            end
         end
      end
      bonus = 1'b0;
      checks++;
      if (sb_q.size() != 0 || ntick != 5) begin
         errors++;
         $display("FAIL save_count ticks=%0d pending=%0d required 5 0", ntick, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_over();
      bonus = 1'b1; pause = 1'b1; step();
      bonus = 1'b0; step();
      pause = 1'b0; step();
      checks++;
      if (seconds !== 7'd0 || over !== 1'b1 || warn !== 1'b0 || tick !== 1'b0) begin
         errors++;
         $display("FAIL over_ignore sec=%0d over=%b warn=%b tick=%b required 0 1 0 0", seconds, over, warn, tick);
      end
      pulse_restart();
      checks++;
      if (seconds !== 7'd3 || over !== 1'b0 || tens !== 4'd0 || ones !== 4'd3) begin
         errors++;
         $display("FAIL over_restart sec=%0d over=%b tens=%0d ones=%0d required 3 0 0 3", seconds, over, tens, ones);
      end
   endtask

   task automatic test_reset_mid();
      int ntick;
      pulse_restart();
      for (int c = 0; c < 6; c++) step();
      checks++;
      if (seconds !== 7'd2 || warn !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset sec=%0d warn=%b required 2 1", seconds, warn);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (seconds !== 7'd3 || warn !== 1'b0 || over !== 1'b0 || tick !== 1'b0 ||
          tens !== 4'd0 || ones !== 4'd3) begin
         errors++;
         $display("FAIL async_reset sec=%0d warn=%b over=%b tick=%b required 3 0 0 0", seconds, warn, over, tick);
      end
      checks++;
      if (seconds2 !== 7'd42 || tens2 !== 4'd4 || ones2 !== 4'd2) begin
         errors++;
         $display("FAIL async_reset42 sec=%0d tens=%0d ones=%0d required 42 4 2", seconds2, tens2, ones2);
      end
      step();
      rst_n = 1'b1;
      ntick = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (tick === 1'b1) ntick++;
      end
      checks++;
      if (ntick != 0 || seconds !== 7'd3) begin
         errors++;
         $display("FAIL reset_idle ticks=%0d sec=%0d required 0 3", ntick, seconds);
      end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_pause();
      test_bonus();
      test_bonus_on_tick();
      test_over();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
